// File: rtl/axis_fifo_pkg.sv
// Shared types for the AXIS <-> FIFO bridge blocks.
// Holds the controller state enum, stats width and beat counter width helper.
package axis_fifo_pkg;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RECV = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam int STATS_W = 16;

   // Wide enough to hold NUM_TO_WRITE-1 with one bit of headroom.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/axis_frame_len_checker.sv
// Frame length checker: counts accepted beats and flags length errors.
// Ports: clk, rst, acc/tlast in; beat_cnt, frame_done, err_short, err_long, drop_req out.
module axis_frame_len_checker
   import axis_fifo_pkg::*;
#(
   parameter int NUM_TO_WRITE = 10,
   localparam int CW = cnt_width(NUM_TO_WRITE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          acc,
   input  logic          tlast,
   output logic [CW-1:0] beat_cnt,
   output logic          frame_done,
   output logic          err_short,
   output logic          err_long,
   output logic          drop_req
);

   localparam logic [CW-1:0] LAST = CW'(NUM_TO_WRITE - 1);

   logic at_last;

   assign at_last  = (beat_cnt == LAST);
   // Beat NUM_TO_WRITE without tlast: the rest of the frame must be dropped.
   assign drop_req = acc & at_last & ~tlast;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt   <= '0;
         frame_done <= 1'b0;
         err_short  <= 1'b0;
         err_long   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         err_short  <= 1'b0;
         err_long   <= 1'b0;
         if (acc) begin
            if (at_last) begin
               beat_cnt   <= '0;
               frame_done <= tlast;
               err_long   <= ~tlast;
            end else if (tlast) begin
               beat_cnt  <= '0;
               err_short <= 1'b1;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/axis_fifo_writer.sv
// AXI4-Stream slave writing fixed-length frames into a synchronous FIFO.
// Ports: clk, rst; s_axis_tvalid/tready/tdata/tlast; din, wr_en, full;
// frame_done, err_short, err_long pulses; beat_cnt.
// Optional AXIS_FIFO_WRITER_STATS_EN adds good_frames, short_frames, long_frames.
module axis_fifo_writer
   import axis_fifo_pkg::*;
#(
   parameter int NUM_TO_WRITE = 10,
   parameter int DATA_WIDTH   = 16,
   localparam int CW = cnt_width(NUM_TO_WRITE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] din,
   output logic                  wr_en,
   input  logic                  full,
   output logic                  frame_done,
   output logic                  err_short,
   output logic                  err_long,
   output logic [CW-1:0]         beat_cnt
`ifdef AXIS_FIFO_WRITER_STATS_EN
   ,
   output logic [STATS_W-1:0]    good_frames,
   output logic [STATS_W-1:0]    short_frames,
   output logic [STATS_W-1:0]    long_frames
`endif
);

   state_t state;
   state_t state_nxt;
   logic   acc;
   logic   acc_recv;
   logic   drop_req;

   assign acc      = s_axis_tvalid & s_axis_tready;
   assign acc_recv = acc & (state == RECV);
   assign wr_en    = acc_recv;
   assign din      = s_axis_tdata;

   always_ff @(posedge clk) begin
      if (rst) state <= INIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         INIT:    state_nxt = RECV;
         RECV:    if (drop_req) state_nxt = DROP;
         DROP:    if (acc && s_axis_tlast) state_nxt = RECV;
         default: state_nxt = INIT;
      endcase
   end

   // Ready is forced low during reset so nothing is accepted mid-reset.
   always_comb begin
      s_axis_tready = 1'b0;
      if (!rst) begin
         unique case (state)
            INIT:    s_axis_tready = 1'b0;
            RECV:    s_axis_tready = ~full;
            DROP:    s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
         endcase
      end
   end

   axis_frame_len_checker #(
      .NUM_TO_WRITE(NUM_TO_WRITE)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .acc       (acc_recv),
      .tlast     (s_axis_tlast),
      .beat_cnt  (beat_cnt),
      .frame_done(frame_done),
      .err_short (err_short),
      .err_long  (err_long),
      .drop_req  (drop_req)
   );

`ifdef AXIS_FIFO_WRITER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         good_frames  <= '0;
         short_frames <= '0;
         long_frames  <= '0;
      end else begin
         if (frame_done && good_frames != '1)
            good_frames <= good_frames + 1'b1;
         if (err_short && short_frames != '1)
            short_frames <= short_frames + 1'b1;
         if (err_long && long_frames != '1)
            long_frames <= long_frames + 1'b1;
      end
   end
`endif

endmodule
